// File: rtl/cpu_pkg.sv
// Shared definitions for the main control unit and alu_control: opcodes,
// ALU operation types, mux encodings and the control state encoding.
package cpu_pkg;

    // Opcode field values, instr[15:12]
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b1000;
    localparam logic [3:0] OP_SW    = 4'b1011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_BNE   = 4'b0101;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // ALU operation types consumed by alu_control
    localparam logic [1:0] ALU_TYPE_A = 2'b00;
    localparam logic [1:0] ALU_TYPE_B = 2'b01;
    localparam logic [1:0] ALU_TYPE_C = 2'b10;
    localparam logic [1:0] ALU_TYPE_D = 2'b11;

    // ALU B-operand mux select
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_TWO   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;

    // PC source mux select
    localparam logic [1:0] PC_ALU     = 2'b00;
    localparam logic [1:0] PC_BRANCH  = 2'b01;
    localparam logic [1:0] PC_JUMP    = 2'b10;

    // Control states; codes 11..15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_RWB      = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_HALT     = 4'd10
    } state_t;

    // True for every opcode the control unit knows how to sequence
    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JMP, OP_HALT: is_legal = 1'b1;
            default:                                                 is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/main_control_fsm.sv
// Multi-cycle main control unit: fetches an instruction, latches its opcode
// and function fields, and steps it through its execution phases while
// driving the datapath strobes and mux selects.
module main_control_fsm
    import cpu_pkg::*;
#(
    parameter int OPC_W = 4,
    parameter int FN_W  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     instr,
    input  logic            mem_ready,
    input  logic            zero,
    output logic [1:0]      alu_op,
    output logic [FN_W-1:0] funct_code,
    output logic            ir_write,
    output logic            pc_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            reg_write,
    output logic            mem_to_reg,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      pc_src,
    output logic            halted,
    output logic            illegal_op,
    output logic [3:0]      state
);

    state_t             state_q;
    logic [OPC_W-1:0]   opcode_q;
    logic [FN_W-1:0]    funct_q;

    // Register-number and immediate bits belong to the datapath, not here
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[15-OPC_W:FN_W];

    // State sequencing plus opcode/function latching on a completed fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            funct_q  <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        opcode_q <= instr[15 -: OPC_W];
                        funct_q  <= instr[FN_W-1:0];
                        state_q  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (opcode_q)
                        OP_RTYPE:      state_q <= S_EXEC_R;
                        OP_LW, OP_SW:  state_q <= S_MEM_ADDR;
                        OP_BEQ, OP_BNE: state_q <= S_BRANCH;
                        OP_JMP:        state_q <= S_JUMP;
                        OP_HALT:       state_q <= S_HALT;
                        default:       state_q <= S_FETCH;
                    endcase
                end
                S_EXEC_R:   state_q <= S_RWB;
                S_RWB:      state_q <= S_FETCH;
                S_MEM_ADDR: state_q <= (opcode_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   if (mem_ready) state_q <= S_MEM_WB;
                S_MEM_WB:   state_q <= S_FETCH;
                S_MEM_WR:   if (mem_ready) state_q <= S_FETCH;
                S_BRANCH:   state_q <= S_FETCH;
                S_JUMP:     state_q <= S_FETCH;
                S_HALT:     state_q <= S_HALT;
                default:    state_q <= S_FETCH;
            endcase
        end
    end

    // Per-state outputs; FETCH strobes and the branch pc_write follow their inputs
    always_comb begin
        alu_op     = ALU_TYPE_A;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_b  = SRCB_REG;
        pc_src     = PC_ALU;
        halted     = 1'b0;
        illegal_op = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_TWO;
                    pc_src    = PC_ALU;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: illegal_op = ~is_legal(opcode_q);
                S_EXEC_R: begin
                    alu_op    = ALU_TYPE_A;
                    alu_src_b = SRCB_REG;
                end
                S_RWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b0;
                end
                S_MEM_ADDR: begin
                    alu_op    = ALU_TYPE_B;
                    alu_src_b = SRCB_IMM;
                end
                S_MEM_RD: mem_read = 1'b1;
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: mem_write = 1'b1;
                S_BRANCH: begin
                    alu_op    = ALU_TYPE_C;
                    alu_src_b = SRCB_REG;
                    pc_src    = PC_BRANCH;
                    pc_write  = (opcode_q == OP_BEQ) ? zero : ~zero;
                end
                S_JUMP: begin
                    alu_op   = ALU_TYPE_D;
                    pc_src   = PC_JUMP;
                    pc_write = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign funct_code = rst ? '0 : funct_q;
    assign state      = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm: each instruction is expanded from its class
// into a list of expected per-cycle output bundles, then played cycle by
// cycle against the DUT with random wait states and ignored inputs.
module tb_main_control_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        mem_ready;
    logic        zero;
    logic [1:0]  alu_op;
    logic [3:0]  funct_code;
    logic        ir_write, pc_write, mem_read, mem_write, reg_write, mem_to_reg;
    logic [1:0]  alu_src_b, pc_src;
    logic        halted, illegal_op;
    logic [3:0]  state;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [7:0] IRW = 8'h80;
    localparam logic [7:0] PCW = 8'h40;
    localparam logic [7:0] MRD = 8'h20;
    localparam logic [7:0] MWR = 8'h10;
    localparam logic [7:0] RGW = 8'h08;
    localparam logic [7:0] M2R = 8'h04;
    localparam logic [7:0] HLT = 8'h02;
    localparam logic [7:0] ILL = 8'h01;

    typedef struct packed {
        logic [3:0] st;
        logic [7:0] sb;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] p;
        logic [3:0] fn;
        logic       rdy;
        logic       z;
    } exp_t;

    exp_t       q[$];
    logic [3:0] exp_funct;

    main_control_fsm dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .zero(zero),
        .alu_op(alu_op), .funct_code(funct_code), .ir_write(ir_write),
        .pc_write(pc_write), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .halted(halted), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    // Compare the full output bundle and the read/write exclusion
    task automatic checkOutput(input string tag, input logic [21:0] expv);
        logic [21:0] obs;
        obs = {state, ir_write, pc_write, mem_read, mem_write, reg_write, mem_to_reg,
               halted, illegal_op, alu_op, alu_src_b, pc_src, funct_code};
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
        vectors++;
        assert ((mem_read & mem_write) === 1'b0) else begin
            miscompares++;
            $error("[TB] FAIL %s rd_wr_excl: observed rd=%b wr=%b expected not both", tag, mem_read, mem_write);
        end
    endtask

    task automatic add(input logic [3:0] st, input logic [7:0] sb, input logic [1:0] a,
                       input logic [1:0] b, input logic [1:0] p, input logic rdy, input logic z);
        exp_t r;
        r.st = st; r.sb = sb; r.a = a; r.b = b; r.p = p;
        r.fn = exp_funct; r.rdy = rdy; r.z = z;
        q.push_back(r);
    endtask

    // Expand one instruction into its expected cycle sequence
    task automatic build(input logic [15:0] ins, input int wf, input int wm,
                         input logic z, input int hold);
        logic [3:0] op;
        logic       taken;
        op = ins[15:12];
        for (int w = 0; w < wf; w++) add(4'd0, MRD, 2'b00, 2'b01, 2'b00, 1'b0, 1'($urandom));
        add(4'd0, IRW | PCW | MRD, 2'b00, 2'b01, 2'b00, 1'b1, 1'($urandom));
        exp_funct = ins[3:0];
        add(4'd1, (op inside {4'b0000, 4'b1000, 4'b1011, 4'b0100, 4'b0101, 4'b1100, 4'b1111}) ? 8'h00 : ILL,
            2'b00, 2'b00, 2'b00, 1'($urandom), 1'($urandom));
        case (op)
            4'b0000: begin
                add(4'd2, 8'h00, 2'b00, 2'b00, 2'b00, 1'($urandom), 1'($urandom));
                add(4'd3, RGW, 2'b00, 2'b00, 2'b00, 1'($urandom), 1'($urandom));
            end
            4'b1000: begin
                add(4'd4, 8'h00, 2'b01, 2'b10, 2'b00, 1'($urandom), 1'($urandom));
                for (int w = 0; w < wm; w++) add(4'd5, MRD, 2'b00, 2'b00, 2'b00, 1'b0, 1'($urandom));
                add(4'd5, MRD, 2'b00, 2'b00, 2'b00, 1'b1, 1'($urandom));
                add(4'd6, RGW | M2R, 2'b00, 2'b00, 2'b00, 1'($urandom), 1'($urandom));
            end
            4'b1011: begin
                add(4'd4, 8'h00, 2'b01, 2'b10, 2'b00, 1'($urandom), 1'($urandom));
                for (int w = 0; w < wm; w++) add(4'd7, MWR, 2'b00, 2'b00, 2'b00, 1'b0, 1'($urandom));
                add(4'd7, MWR, 2'b00, 2'b00, 2'b00, 1'b1, 1'($urandom));
            end
            4'b0100, 4'b0101: begin
                taken = (op == 4'b0100) ? z : ~z;
                add(4'd8, taken ? PCW : 8'h00, 2'b10, 2'b00, 2'b01, 1'($urandom), z);
            end
            4'b1100: add(4'd9, PCW, 2'b11, 2'b00, 2'b10, 1'($urandom), 1'($urandom));
            4'b1111: for (int h = 0; h < hold; h++) add(4'd10, HLT, 2'b00, 2'b00, 2'b00, 1'($urandom), 1'($urandom));
            default: ;
        endcase
    endtask

    // Play the expected sequence; at abort_at the cycle becomes a reset cycle
    task automatic applyStimulus(input logic [15:0] ins, input int abort_at);
        exp_t r;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            rst = 1'b0;
            r = q[i];
            if (i == abort_at) begin
                rst = 1'b1; mem_ready = 1'b0; instr = 16'($urandom); zero = 1'($urandom);
                #1;
                checkOutput($sformatf("abort_%h_c%0d", ins, i), 22'h0);
                exp_funct = 4'h0;
                break;
            end
            mem_ready = r.rdy;
            zero      = r.z;
            instr     = (r.st == 4'd0 && r.rdy) ? ins : 16'($urandom);
            #1;
            checkOutput($sformatf("i%h_c%0d", ins, i), {r.st, r.sb, r.a, r.b, r.p, r.fn});
        end
        q.delete();
    endtask

    task automatic run(input logic [15:0] ins, input int wf, input int wm, input logic z);
        build(ins, wf, wm, z, 0);
        applyStimulus(ins, -1);
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'($urandom); instr = 16'($urandom); zero = 1'($urandom);
        #1;
        checkOutput(tag, 22'h0);
        exp_funct = 4'h0;
    endtask

    logic [3:0] illegal_ops [9] = '{4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b0111,
                                     4'b1001, 4'b1010, 4'b1101, 4'b1110};
    logic [3:0] legal_ops   [6] = '{4'b0000, 4'b1000, 4'b1011, 4'b0100, 4'b0101, 4'b1100};

    initial begin
        logic [3:0]  op;
        logic [15:0] ins;
        rst = 1'b1; mem_ready = 1'b0; instr = 16'h0; zero = 1'b0;
        exp_funct = 4'h0;

        doReset("reset_initial");

        run(16'h0A3F, 0, 0, 1'b0);
        run(16'h8123, 0, 2, 1'b0);
        run(16'h4120, 0, 0, 1'b1);
        run(16'h4120, 0, 0, 1'b0);
        run(16'hB456, 0, 0, 1'b0);
        run(16'hC000, 0, 0, 1'b0);
        run(16'h2000, 0, 0, 1'b0);
        run(16'h5007, 2, 0, 1'b0);
        run(16'h5009, 1, 0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 6) == 0) op = illegal_ops[$urandom_range(0, 8)];
            else                           op = legal_ops[$urandom_range(0, 5)];
            ins = {op, 12'($urandom)};
            run(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end

        build(16'hB456, 0, 3, 1'b0, 0);
        applyStimulus(16'hB456, 4);
        run(16'h0125, 0, 0, 1'b0);

        build(16'hF000, 1, 0, 1'b0, 6);
        applyStimulus(16'hF000, -1);
        doReset("reset_from_halt");
        run(16'h0A3F, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
